// File: rtl/stride_vp_top.sv
// Multi-lane stride value predictor: per-entry last value, stride and confidence, with mispredictions computed from feedback.
// Optional define STRIDE_VP_BYPASS_EN forwards a same-cycle winning feedback write to a forward read of the same index.
module stride_vp_top #(
  parameter int P_STORAGE_SIZE = 2048,
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_CONF_WIDTH   = 8,
  parameter int P_NUM_PRED     = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [P_NUM_PRED-1:0][31:0]             fw_pc_i,
  input  logic [P_NUM_PRED-1:0]                   fw_valid_i,
  output logic [P_NUM_PRED-1:0][31:0]             pred_pc_o,
  output logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0] pred_result_o,
  output logic [P_NUM_PRED-1:0]                   pred_conf_o,
  output logic [P_NUM_PRED-1:0]                   pred_valid_o,
  input  logic [P_NUM_PRED-1:0][31:0]             fb_pc_i,
  input  logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0] fb_actual_i,
  input  logic [P_NUM_PRED-1:0]                   fb_valid_i,
  output logic [P_NUM_PRED-1:0]                   fb_mispredict_o
);

  localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);

  typedef logic [P_INDEX_WIDTH-1:0] idx_t;
  typedef logic [P_DATA_WIDTH-1:0]  data_t;
  typedef logic [P_CONF_WIDTH-1:0]  conf_t;

  typedef struct packed {
    data_t last;
    data_t stride;
    conf_t conf;
    logic  seen;
  } entry_t;

  entry_t table_q [P_STORAGE_SIZE];

  idx_t   [P_NUM_PRED-1:0] fb_idx;
  idx_t   [P_NUM_PRED-1:0] fw_idx;
  entry_t [P_NUM_PRED-1:0] fb_old;
  entry_t [P_NUM_PRED-1:0] fb_new;
  entry_t [P_NUM_PRED-1:0] fw_entry;
  data_t  [P_NUM_PRED-1:0] fb_delta;
  data_t  [P_NUM_PRED-1:0] fw_result_d;
  logic   [P_NUM_PRED-1:0] fw_conf_d;
  logic   [P_NUM_PRED-1:0] fb_win;
  logic   [P_NUM_PRED-1:0] fb_mis_d;

  // Only the low PC bits index the table; the rest of the feedback PC is deliberately ignored.
  logic unused_fb_pc;
  assign unused_fb_pc = ^fb_pc_i;

  always_comb begin
    for (int l = 0; l < P_NUM_PRED; l++) begin
      fb_idx[l] = fb_pc_i[l][P_INDEX_WIDTH-1:0];
      fw_idx[l] = fw_pc_i[l][P_INDEX_WIDTH-1:0];
    end
  end

  // Feedback: resolve same-index conflicts (highest valid lane wins) and build the updated entry.
  always_comb begin
    for (int l = 0; l < P_NUM_PRED; l++) begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      fb_old[l]   = table_q[fb_idx[l]];
      fb_new[l]   = fb_old[l];
      fb_delta[l] = fb_actual_i[l] - fb_old[l].last;
      fb_win[l]   = fb_valid_i[l];
      for (int k = 0; k < P_NUM_PRED; k++) begin
        if (k > l && fb_valid_i[k] && fb_idx[k] == fb_idx[l]) begin
          fb_win[l] = 1'b0;
        end
      end

      fb_new[l].last = fb_actual_i[l];
      fb_new[l].seen = 1'b1;
      if (!fb_old[l].seen) begin
        fb_new[l].stride = '0;
        fb_new[l].conf   = '0;
      end else if (fb_delta[l] == fb_old[l].stride) begin
        if (!(&fb_old[l].conf)) begin
          fb_new[l].conf = fb_old[l].conf + 1'b1;
        end
      end else begin
        fb_new[l].stride = fb_delta[l];
        fb_new[l].conf   = '0;
      end

      // A stride miss (delta != stride) is exactly last+stride != actual.
      fb_mis_d[l] = fb_win[l] &&
                    (!fb_old[l].seen || (fb_old[l].last + fb_old[l].stride) != fb_actual_i[l]);
    end
  end

  // Forward read path.
  always_comb begin
    for (int l = 0; l < P_NUM_PRED; l++) begin
      fw_entry[l] = table_q[fw_idx[l]];
`ifdef STRIDE_VP_BYPASS_EN
      // Winning writes have distinct indices, so at most one lane can match.
      for (int k = 0; k < P_NUM_PRED; k++) begin
        if (fb_win[k] && fb_idx[k] == fw_idx[l]) begin
          fw_entry[l] = fb_new[k];
        end
      end
`endif
      fw_result_d[l] = fw_entry[l].last + fw_entry[l].stride;
      fw_conf_d[l]   = fw_entry[l].conf[P_CONF_WIDTH-1];
    end
  end

  // NOTE: the table is held in flops with async reset because a reset must clear every entry
  // at once; a RAM macro could not meet that and would need a sequenced clear instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < P_STORAGE_SIZE; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      for (int l = 0; l < P_NUM_PRED; l++) begin
        if (fb_win[l]) begin
          table_q[fb_idx[l]] <= fb_new[l];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_pc_o       <= '0;
      pred_result_o   <= '0;
      pred_conf_o     <= '0;
      pred_valid_o    <= '0;
      fb_mispredict_o <= '0;
    end else begin
      pred_pc_o       <= fw_pc_i;
      pred_valid_o    <= fw_valid_i;
      fb_mispredict_o <= fb_mis_d;
      for (int l = 0; l < P_NUM_PRED; l++) begin
        if (fw_valid_i[l]) begin
          pred_result_o[l] <= fw_result_d[l];
          pred_conf_o[l]   <= fw_conf_d[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_stride_vp_top.sv
// Self-checking bench for stride_vp_top: directed vector table, hand-written corner sequences,
// and randomized traffic against a table-level reference model.
module tb_stride_vp_top;

  localparam int SZ = 1024;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam int N  = 2;

  logic                     clk_i;
  logic                     rst_ni;
  logic [N-1:0][31:0]       fw_pc;
  logic [N-1:0]             fw_valid;
  logic [N-1:0][31:0]       pred_pc;
  logic [N-1:0][W-1:0]      pred_result;
  logic [N-1:0]             pred_conf;
  logic [N-1:0]             pred_valid;
  logic [N-1:0][31:0]       fb_pc;
  logic [N-1:0][W-1:0]      fb_actual;
  logic [N-1:0]             fb_valid;
  logic [N-1:0]             fb_mispredict;

  stride_vp_top #(
    .P_STORAGE_SIZE (SZ),
    .P_DATA_WIDTH   (W),
    .P_CONF_WIDTH   (CW),
    .P_NUM_PRED     (N)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .fw_pc_i         (fw_pc),
    .fw_valid_i      (fw_valid),
    .pred_pc_o       (pred_pc),
    .pred_result_o   (pred_result),
    .pred_conf_o     (pred_conf),
    .pred_valid_o    (pred_valid),
    .fb_pc_i         (fb_pc),
    .fb_actual_i     (fb_actual),
    .fb_valid_i      (fb_valid),
    .fb_mispredict_o (fb_mispredict)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the table as plain arrays, updated by the predictor's rules.
  logic [W-1:0]  m_last   [SZ];
  logic [W-1:0]  m_stride [SZ];
  logic [CW-1:0] m_conf   [SZ];
  bit            m_seen   [SZ];
  logic [W-1:0]  e_res  [N];
  bit            e_conf [N];
  bit            e_pv   [N];
  bit            e_mis  [N];
  logic [31:0]   e_pc   [N];

  task automatic model_reset();
    for (int i = 0; i < SZ; i++) begin
      m_last[i] = '0; m_stride[i] = '0; m_conf[i] = '0; m_seen[i] = 0;
    end
    for (int l = 0; l < N; l++) begin
      e_res[l] = '0; e_conf[l] = 0; e_pv[l] = 0; e_mis[l] = 0; e_pc[l] = '0;
    end
  endtask

  task automatic model_forward();
    int idx;
    for (int l = 0; l < N; l++) begin
      if (fw_valid[l]) begin
        idx = int'(fw_pc[l] % SZ);
        e_res[l]  = m_last[idx] + m_stride[idx];
        e_conf[l] = m_conf[idx][CW-1];
      end
    end
  endtask

  task automatic model_step();
    bit claimed [int];
    bit win [N];
    int idx;
    logic [W-1:0] d;
    for (int l = N - 1; l >= 0; l--) begin
      idx = int'(fb_pc[l] % SZ);
      win[l] = fb_valid[l] && !claimed.exists(idx);
      if (win[l]) claimed[idx] = 1;
    end
`ifndef STRIDE_VP_BYPASS_EN
    model_forward();
`endif
    for (int l = 0; l < N; l++) begin
      e_mis[l] = 0;
      if (win[l]) begin
        idx = int'(fb_pc[l] % SZ);
        e_mis[l] = !m_seen[idx] || ((m_last[idx] + m_stride[idx]) != fb_actual[l]);
        d = fb_actual[l] - m_last[idx];
        if (!m_seen[idx]) begin
          m_stride[idx] = '0;
          m_conf[idx]   = '0;
          m_seen[idx]   = 1;
        end else if (d == m_stride[idx]) begin
          if (m_conf[idx] != {CW{1'b1}}) m_conf[idx] = m_conf[idx] + 1'b1;
        end else begin
          m_stride[idx] = d;
          m_conf[idx]   = '0;
        end
        m_last[idx] = fb_actual[l];
      end
    end
`ifdef STRIDE_VP_BYPASS_EN
    model_forward();
`endif
    for (int l = 0; l < N; l++) begin
      e_pc[l] = fw_pc[l];
      e_pv[l] = fw_valid[l];
    end
  endtask

  task automatic compare_model(input string tag);
    for (int l = 0; l < N; l++) begin
      check($sformatf("%s pred_valid[%0d]", tag, l), pred_valid[l], e_pv[l]);
      check($sformatf("%s pred_pc[%0d]", tag, l), pred_pc[l], e_pc[l]);
      check($sformatf("%s pred_result[%0d]", tag, l), pred_result[l], e_res[l]);
      check($sformatf("%s pred_conf[%0d]", tag, l), pred_conf[l], e_conf[l]);
      check($sformatf("%s mispredict[%0d]", tag, l), fb_mispredict[l], e_mis[l]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int l = 0; l < N; l++) begin
      check($sformatf("%s pred_pc[%0d]", tag, l), pred_pc[l], 0);
      check($sformatf("%s pred_result[%0d]", tag, l), pred_result[l], 0);
      check($sformatf("%s pred_conf[%0d]", tag, l), pred_conf[l], 0);
      check($sformatf("%s pred_valid[%0d]", tag, l), pred_valid[l], 0);
      check($sformatf("%s mispredict[%0d]", tag, l), fb_mispredict[l], 0);
    end
  endtask

  task automatic clear_inputs();
    fw_pc = '0; fw_valid = '0; fb_pc = '0; fb_actual = '0; fb_valid = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Directed vectors: one active lane per row, expected outputs one edge later.
  typedef struct {
    int          lane;
    logic [31:0] fb_pc;
    logic [31:0] fb_act;
    bit          fb_v;
    logic [31:0] fw_pc;
    bit          fw_v;
    bit          e_mis;
    bit          e_pv;
    logic [31:0] e_res;
    bit          e_conf;
  } vec_t;

  function automatic vec_t mk(int lane, logic [31:0] fbp, logic [31:0] fba, bit fbv,
                              logic [31:0] fwp, bit fwv, bit mis, bit pv,
                              logic [31:0] res, bit conf);
    vec_t v;
    v.lane = lane; v.fb_pc = fbp; v.fb_act = fba; v.fb_v = fbv;
    v.fw_pc = fwp; v.fw_v = fwv; v.e_mis = mis; v.e_pv = pv; v.e_res = res; v.e_conf = conf;
    return v;
  endfunction

  // Random stimulus generator: a small PC pool (two aliasing on one index) with mostly regular strides.
  logic [31:0] pool_pc    [6] = '{32'h40, 32'h44, 32'h48, 32'h440, 32'h1C8, 32'hFFC};
  logic [W-1:0] gen_last   [6];
  logic [W-1:0] gen_stride [6];

  task automatic randomize_inputs();
    int p;
    for (int l = 0; l < N; l++) begin
      fw_valid[l] = ($urandom_range(0, 9) < 7);
      fw_pc[l]    = pool_pc[$urandom_range(0, 5)];
      fb_valid[l] = ($urandom_range(0, 9) < 7);
      p = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) gen_stride[p] = $urandom;
      gen_last[p]  = gen_last[p] + gen_stride[p];
      fb_pc[l]     = pool_pc[p];
      fb_actual[l] = gen_last[p];
    end
  endtask

  vec_t vecs[$];
  logic [31:0] hazard_res;
  int other;

  initial begin
    rst_ni = 1'b1;
    clear_inputs();
    model_reset();
    for (int p = 0; p < 6; p++) begin
      gen_last[p]   = $urandom;
      gen_stride[p] = $urandom_range(0, 16);
    end
    #2 rst_ni = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    rst_ni = 1'b1;

`ifdef STRIDE_VP_BYPASS_EN
    hazard_res = 32'd34;
`else
    hazard_res = 32'd30;
`endif
    // Stride learning on 0x40, read, stride break, read.
    vecs.push_back(mk(0, 32'h40, 32'd10,  1, 0, 0, 1, 0, 32'd0,   0));
    vecs.push_back(mk(0, 32'h40, 32'd14,  1, 0, 0, 1, 0, 32'd0,   0));
    vecs.push_back(mk(0, 32'h40, 32'd18,  1, 0, 0, 0, 0, 32'd0,   0));
    vecs.push_back(mk(0, 32'h40, 32'd22,  1, 0, 0, 0, 0, 32'd0,   0));
    vecs.push_back(mk(0, 32'h40, 32'd26,  1, 0, 0, 0, 0, 32'd0,   0));
    vecs.push_back(mk(0, 0,      0,       0, 32'h40, 1, 0, 1, 32'd30,  1));
    vecs.push_back(mk(0, 32'h40, 32'd100, 1, 0, 0, 1, 0, 32'd30,  1));
    vecs.push_back(mk(0, 0,      0,       0, 32'h40, 1, 0, 1, 32'd174, 0));
    // Wrap-around: last 0xFFFFFFFE, stride 3.
    vecs.push_back(mk(0, 32'h100, 32'hFFFF_FFF8, 1, 0, 0, 1, 0, 32'd174, 0));
    vecs.push_back(mk(0, 32'h100, 32'hFFFF_FFFB, 1, 0, 0, 1, 0, 32'd174, 0));
    vecs.push_back(mk(0, 32'h100, 32'hFFFF_FFFE, 1, 0, 0, 0, 0, 32'd174, 0));
    vecs.push_back(mk(0, 0,       0,             0, 32'h100, 1, 0, 1, 32'd1, 0));
    // Same-cycle hazard on lane 1.
    vecs.push_back(mk(1, 32'hC0, 32'd10, 1, 0, 0, 1, 0, 32'd0, 0));
    vecs.push_back(mk(1, 32'hC0, 32'd14, 1, 0, 0, 1, 0, 32'd0, 0));
    vecs.push_back(mk(1, 32'hC0, 32'd18, 1, 0, 0, 0, 0, 32'd0, 0));
    vecs.push_back(mk(1, 32'hC0, 32'd22, 1, 0, 0, 0, 0, 32'd0, 0));
    vecs.push_back(mk(1, 32'hC0, 32'd26, 1, 0, 0, 0, 0, 32'd0, 0));
    vecs.push_back(mk(1, 32'hC0, 32'd30, 1, 32'hC0, 1, 0, 1, hazard_res, 1));
    vecs.push_back(mk(1, 0,      0,      0, 32'hC0, 1, 0, 1, 32'd34, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      clear_inputs();
      fb_pc[vecs[i].lane]     = vecs[i].fb_pc;
      fb_actual[vecs[i].lane] = vecs[i].fb_act;
      fb_valid[vecs[i].lane]  = vecs[i].fb_v;
      fw_pc[vecs[i].lane]     = vecs[i].fw_pc;
      fw_valid[vecs[i].lane]  = vecs[i].fw_v;
      model_step();
      tick();
      other = 1 - vecs[i].lane;
      check($sformatf("vec%0d mispredict", i), fb_mispredict[vecs[i].lane], vecs[i].e_mis);
      check($sformatf("vec%0d pred_valid", i), pred_valid[vecs[i].lane], vecs[i].e_pv);
      check($sformatf("vec%0d pred_result", i), pred_result[vecs[i].lane], vecs[i].e_res);
      check($sformatf("vec%0d pred_conf", i), pred_conf[vecs[i].lane], vecs[i].e_conf);
      check($sformatf("vec%0d idle mispredict", i), fb_mispredict[other], 0);
      check($sformatf("vec%0d idle pred_valid", i), pred_valid[other], 0);
    end

    // Lane conflict on 0x80: lane 1 wins, lane 0 is silent.
    clear_inputs();
    fb_pc[0] = 32'h80; fb_actual[0] = 32'd5;
    fb_pc[1] = 32'h80; fb_actual[1] = 32'd9;
    fb_valid = 2'b11;
    model_step();
    tick();
    check("conflict mispredict[0]", fb_mispredict[0], 0);
    check("conflict mispredict[1]", fb_mispredict[1], 1);
    clear_inputs();
    fw_pc[0] = 32'h80; fw_pc[1] = 32'h80; fw_valid = 2'b11;
    model_step();
    tick();
    check("conflict read result[0]", pred_result[0], 32'd9);
    check("conflict read result[1]", pred_result[1], 32'd9);
    check("conflict read conf[0]", pred_conf[0], 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      model_step();
      tick();
      compare_model("rnd1");
    end

    // Reset in the middle of traffic: outputs clear immediately and stay clear.
    randomize_inputs();
    rst_ni = 1'b0;
    #1 check_all_zero("midreset async");
    model_reset();
    tick();
    randomize_inputs();
    tick();
    check_all_zero("midreset held");
    rst_ni = 1'b1;
    clear_inputs();
    fw_pc[0] = 32'h40; fw_pc[1] = 32'h80; fw_valid = 2'b11;
    model_step();
    tick();
    for (int l = 0; l < N; l++) begin
      check($sformatf("post-reset read result[%0d]", l), pred_result[l], 0);
      check($sformatf("post-reset read conf[%0d]", l), pred_conf[l], 0);
      check($sformatf("post-reset read valid[%0d]", l), pred_valid[l], 1);
    end

    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      model_step();
      tick();
      compare_model("rnd2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
